instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 8-bit teaching CPU.
- Replaces the free-running one-bit machine-cycle toggle with an FSM that produces the `sm` phase bit and the `sm_en`/`ir_ld` strobes consumed by the control-signal decoder.
- Stalls on memory readiness and on the IN/OUT port handshakes; stops cleanly on HALT or timeout.
- Sits between RAM/IO ready lines and the combinational control decoder.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- WAIT_MAX, 255, max stall cycles in any wait state before the timeout error fires (1..2^16-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous active-low
- start  in  1  one-cycle pulse; leaves IDLE
- ir  in  8  current instruction register; ir[7:4] is the opcode
- ram_rdy  in  1  RAM read/write data valid this cycle
- in_vld  in  1  input port has data
- out_rdy  in  1  output port accepts data
- sm  out  1  phase: 0 = fetch, 1 = execute
- sm_en  out  1  high while the machine is advancing (not IDLE/HALTED)
- ir_ld  out  1  one-cycle IR load strobe
- in_ack  out  1  one-cycle consume strobe to the input port
- out_vld  out  1  output data valid, held until accepted
- busy  out  1  not IDLE and not HALTED
- halted  out  1  in HALTED
- err  out  1  sticky timeout flag
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Reset values: all outputs 0; state is IDLE; counters are 0.
- Asynchronous reset aborts any state immediately. A reset during OUT_WAIT drops `out_vld` at once.
- Opcode classes (package constants): OP_IN=4'h1, OP_OUT=4'h2, OP_MOVI=4'h3, OP_HALT=4'hF. All other opcodes are single-cycle execute.
- IDLE:
  - `sm`=0.
  - `start` -> FETCH.
- FETCH:
  - `sm`=0.
  - Wait for `ram_rdy`. On `ram_rdy`: pulse `ir_ld` and go to EXEC next cycle.
- EXEC (`sm`=1), one cycle; decode the registered `ir`:
  - HALT -> HALTED; `retired`+1.
  - IN -> IN_WAIT.
  - OUT -> OUT_WAIT, with `out_vld` set.
  - MOVI -> IMM_WAIT.
  - Otherwise -> FETCH; `retired`+1.
- IN_WAIT:
  - `sm`=1.
  - On `in_vld`: pulse `in_ack`, `retired`+1, go to FETCH.
- OUT_WAIT:
  - `sm`=1; `out_vld` held high.
  - On `out_rdy`: clear `out_vld` next cycle, `retired`+1, go to FETCH.
- IMM_WAIT:
  - `sm`=1; the immediate byte is read from RAM.
  - On `ram_rdy`: `retired`+1, go to FETCH.
- HALTED:
  - `sm_en`=0, `halted`=1.
  - Only reset exits; `start` is ignored.
- Wait timer:
  - Clears on entry to FETCH, IN_WAIT, OUT_WAIT and IMM_WAIT.
  - Increments each stalled cycle.
  - On reaching WAIT_MAX: set `err` (sticky), go to HALTED, clear `out_vld`.
  - A ready arriving in the same cycle as the count hits WAIT_MAX wins: no error, normal advance.
- `start` outside IDLE is ignored.
- `retired` saturates never; it wraps.
- `sm_en` = 1 in FETCH/EXEC/wait states, 0 in IDLE/HALTED.
- Minimum instruction time is 2 cycles (FETCH with `ram_rdy` high, then EXEC).

Optional Feature:
- Macro: INSTR_SEQUENCER_STEP_EN.
- When defined:
  - Adds input port `step` (1 bit) and a PAUSE state.
  - After each retirement (except HALT), go to PAUSE instead of FETCH. `sm_en`=0 in PAUSE.
  - A `step` pulse moves PAUSE -> FETCH.
  - `start` in IDLE leads to PAUSE rather than FETCH.
- When undefined: no `step` port, no PAUSE state; behaviour exactly as above.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - state enum (IDLE, FETCH, EXEC, IN_WAIT, OUT_WAIT, IMM_WAIT, HALTED, PAUSE);
  - opcode constants OP_IN / OP_OUT / OP_MOVI / OP_HALT;
  - opcode field slice constants (7:4).
- One natural sub-module: `stall_timer` (clear, enable, WAIT_MAX compare, timeout output), instantiated once.

Test Plan:
- Reset, `start`, `ir`=8'h40, `ram_rdy`=1 -> `ir_ld` pulse in cycle 1, `sm`=1 in cycle 2, `retired`=1 in cycle 3, `sm` back to 0.
- `ram_rdy` held low 5 cycles in FETCH -> `sm`=0 and no `ir_ld` for those 5 cycles; `ir_ld` the cycle `ram_rdy` rises; `err`=0.
- `ir`=8'h20 (OUT), `out_rdy` low 3 cycles -> `out_vld`=1 for 4 cycles, drops after acceptance, `retired`+1.
- `ir`=8'h10 (IN) with `in_vld` never high, WAIT_MAX=4 -> after 4 stall cycles `err`=1, `halted`=1, `sm_en`=0; a later `start` has no effect.
- `ir`=8'hF0 -> HALTED; `retired` incremented once. Assert `rst_n` low mid-OUT_WAIT -> `out_vld`=0 immediately, state IDLE.
- With INSTR_SEQUENCER_STEP_EN: two instructions with a single `step` pulse -> exactly one retirement per pulse, `sm_en`=0 while paused.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer state encodings, opcode classes and the opcode field position
package cpu_ctrl_pkg;
  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam logic [3:0] OP_IN = 4'h1;
  localparam logic [3:0] OP_OUT = 4'h2;
  localparam logic [3:0] OP_MOVI = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_EXEC = 3'd2;
  localparam state_t S_IN_WAIT = 3'd3;
  localparam state_t S_OUT_WAIT = 3'd4;
  localparam state_t S_IMM_WAIT = 3'd5;
  localparam state_t S_HALTED = 3'd6;
  localparam state_t S_PAUSE = 3'd7;
  function automatic logic is_wait(input state_t s);
    return s inside {S_FETCH, S_IN_WAIT, S_OUT_WAIT, S_IMM_WAIT};
  endfunction
endpackage

// File: rtl/stall_timer.sv
// stall_timer: counts consecutive stall cycles; timeout marks the stall cycle that reaches WAIT_MAX
module stall_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] nxt;
  always_comb begin
    nxt = {1'b0, cnt_q} + 17'd1;
    cnt_d = clr ? 16'd0 : en ? nxt[15:0] : cnt_q;
  end
  assign timeout = en && nxt == 17'(WAIT_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute FSM producing sm/sm_en/ir_ld with memory and IO stalls.
// Optional single-step mode (step port, PAUSE state) under INSTR_SEQUENCER_STEP_EN.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic             step,
`endif
  input  logic             start,
  input  logic [7:0]       ir,
  input  logic             ram_rdy,
  input  logic             in_vld,
  input  logic             out_rdy,
  output logic             sm,
  output logic             sm_en,
  output logic             ir_ld,
  output logic             in_ack,
  output logic             out_vld,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
`ifdef INSTR_SEQUENCER_STEP_EN
  localparam state_t RESUME = S_PAUSE;
`else
  localparam state_t RESUME = S_FETCH;
`endif
  state_t state_q, state_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0] op;
  logic rdy, stall, retire, clr, timeout, unused_ir;
  assign op = ir[OP_HI:OP_LO];
  assign unused_ir = ^ir[OP_LO-1:0];
  always_comb begin
    rdy = state_q == S_IN_WAIT ? in_vld : state_q == S_OUT_WAIT ? out_rdy : ram_rdy;
    stall = is_wait(state_q) && !rdy;
    retire = 1'b0;
    state_d = state_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: state_d = start ? RESUME : S_IDLE;
      S_FETCH: state_d = rdy ? S_EXEC : S_FETCH;
      S_EXEC: begin
        state_d = op == OP_HALT ? S_HALTED : op == OP_IN ? S_IN_WAIT :
                  op == OP_OUT ? S_OUT_WAIT : op == OP_MOVI ? S_IMM_WAIT : RESUME;
        retire = !(op inside {OP_IN, OP_OUT, OP_MOVI});
      end
      S_IN_WAIT, S_OUT_WAIT, S_IMM_WAIT: begin
        state_d = rdy ? RESUME : state_q;
        retire = rdy;
      end
`ifdef INSTR_SEQUENCER_STEP_EN
      S_PAUSE: state_d = step ? S_FETCH : S_PAUSE;
`endif
      default: ;
    endcase
    // a ready in the limit cycle clears stall, so timeout never overrides an advance
    if (timeout) begin
      state_d = S_HALTED;
      err_d = 1'b1;
    end
    retired_d = retired_q + CNT_W'(retire);
    clr = state_d != state_q;
  end
  stall_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .en(stall),
    .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      retired_q <= retired_d;
    end
  assign sm = state_q inside {S_EXEC, S_IN_WAIT, S_OUT_WAIT, S_IMM_WAIT};
  assign sm_en = sm || state_q == S_FETCH;
  assign ir_ld = state_q == S_FETCH && ram_rdy;
  assign in_ack = state_q == S_IN_WAIT && in_vld;
  assign out_vld = state_q == S_OUT_WAIT;
  assign busy = !(state_q inside {S_IDLE, S_HALTED});
  assign halted = state_q == S_HALTED;
  assign err = err_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of fetch/exec timing, stalls, timeout, halt and async reset
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, ram_rdy, in_vld, out_rdy;
  logic [7:0] ir;
  logic sm, sm_en, ir_ld, in_ack, out_vld, busy, halted, err;
  logic [15:0] retired;
`ifdef INSTR_SEQUENCER_STEP_EN
  logic step = 1'b0;
`endif
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  instr_sequencer #(.CNT_W(16), .WAIT_MAX(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INSTR_SEQUENCER_STEP_EN
    .step(step),
`endif
    .start(start),
    .ir(ir),
    .ram_rdy(ram_rdy),
    .in_vld(in_vld),
    .out_rdy(out_rdy),
    .sm(sm),
    .sm_en(sm_en),
    .ir_ld(ir_ld),
    .in_ack(in_ack),
    .out_vld(out_vld),
    .busy(busy),
    .halted(halted),
    .err(err),
    .retired(retired)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic chk_ret(input string tag);
    logic [31:0] want;
    want = exp_q.size() == 0 ? 32'hDEAD_BEEF : exp_q.pop_front();
    chk(tag, 32'(retired), want);
  endtask
  task automatic chk_idle(input string tag);
    chk(tag, {24'd0, sm, sm_en, ir_ld, in_ack, out_vld, busy, halted, err}, 32'd0);
    chk({tag, "_ret"}, 32'(retired), 32'd0);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; start = 1'b0; ir = 8'h00; ram_rdy = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    #3 chk_idle("reset");
    tick();
    rst_n = 1'b1;
`ifdef INSTR_SEQUENCER_STEP_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("pause_sm_en", 32'(sm_en), 32'd0);
      chk("pause_busy", 32'(busy), 32'd1);
      tick();
    end
    step = 1'b1; ir = 8'h40; ram_rdy = 1'b1;
    tick();
    step = 1'b0;
    #1 chk("step_irld", 32'(ir_ld), 32'd1);
    exp_q.push_back(1);
    tick();
    tick();
    #1 chk_ret("step_ret1");
    chk("paused_after_ret", 32'(sm_en), 32'd0);
    chk("paused_no_irld", 32'(ir_ld), 32'd0);
    tick();
    tick();
    exp_q.push_back(1);
    chk_ret("step_ret_hold");
    step = 1'b1;
    tick();
    step = 1'b0;
    exp_q.push_back(2);
    tick();
    tick();
    #1 chk_ret("step_ret2");
    chk("paused_again", 32'(sm_en), 32'd0);
`else
    start = 1'b1; ir = 8'h40; ram_rdy = 1'b1;
    #1 chk("idle_no_irld", 32'(ir_ld), 32'd0);
    tick();
    start = 1'b0;
    #1 chk("fetch_irld", 32'(ir_ld), 32'd1);
    chk("fetch_sm", 32'(sm), 32'd0);
    chk("fetch_sm_en", 32'(sm_en), 32'd1);
    exp_q.push_back(1);
    tick();
    ram_rdy = 1'b0;
    #1 chk("exec_sm", 32'(sm), 32'd1);
    chk("exec_no_irld", 32'(ir_ld), 32'd0);
    tick();
    chk_ret("ret_first");
    for (int i = 0; i < 5; i++) begin
      #1 chk("fetch_stall", {30'd0, sm, ir_ld}, 32'd0);
      tick();
    end
    ram_rdy = 1'b1; ir = 8'h20;
    #1 chk("ready_at_limit_irld", 32'(ir_ld), 32'd1);
    chk("ready_at_limit_err", 32'(err), 32'd0);
    tick();
    ram_rdy = 1'b0;
    #1 chk("exec_out_vld", 32'(out_vld), 32'd0);
    tick();
    exp_q.push_back(2);
    for (int i = 0; i < 4; i++) begin
      out_rdy = i == 3;
      #1 chk("out_wait_vld", 32'(out_vld), 32'd1);
      chk("out_wait_sm", 32'(sm), 32'd1);
      tick();
    end
    out_rdy = 1'b0; ir = 8'h30; ram_rdy = 1'b1;
    #1 chk("out_dropped", 32'(out_vld), 32'd0);
    chk_ret("ret_out");
    tick();
    ram_rdy = 1'b0;
    tick();
    #1 chk("imm_sm", 32'(sm), 32'd1);
    chk("imm_sm_en", 32'(sm_en), 32'd1);
    tick();
    ram_rdy = 1'b1;
    exp_q.push_back(3);
    tick();
    ir = 8'h10;
    #1 chk_ret("ret_movi");
    tick();
    ram_rdy = 1'b0; in_vld = 1'b1;
    #1 chk("exec_no_in_ack", 32'(in_ack), 32'd0);
    tick();
    #1 chk("in_ack", 32'(in_ack), 32'd1);
    exp_q.push_back(4);
    tick();
    in_vld = 1'b0; ram_rdy = 1'b1;
    #1 chk("in_ack_single", 32'(in_ack), 32'd0);
    chk_ret("ret_in");
    tick();
    ram_rdy = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      #1 chk("in_stall_not_halted", 32'(halted), 32'd0);
      tick();
    end
    #1 chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_sm_en", 32'(sm_en), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    exp_q.push_back(4);
    chk_ret("timeout_no_ret");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("start_ignored", {30'd0, halted, busy}, 32'd2);
    do_reset();
    start = 1'b1; ir = 8'hF0; ram_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    exp_q.push_back(1);
    #1 chk("halt_exec_sm", 32'(sm), 32'd1);
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_no_err", 32'(err), 32'd0);
    chk_ret("halt_ret");
    tick();
    exp_q.push_back(1);
    chk_ret("halt_ret_once");
    do_reset();
    start = 1'b1; ir = 8'h20; ram_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ram_rdy = 1'b0;
    tick();
    #1 chk("pre_reset_out_vld", 32'(out_vld), 32'd1);
    do_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
